// File: rtl/bster_pkg.sv
// Shared helpers for the tree-engine buffering blocks.
// Holds generic queue-operation encodings only; storage geometry stays with each user.
package bster_pkg;

  // Per-cycle queue operation, encoded as {push, pop}
  typedef enum logic [1:0] {
    QOP_NONE = 2'b00,
    QOP_POP  = 2'b01,
    QOP_PUSH = 2'b10,
    QOP_BOTH = 2'b11
  } qop_e;

  // Fold the two handshake strobes into a single operation code
  function automatic qop_e qop_encode(input logic push, input logic pop);
    qop_encode = qop_e'({push, pop});
  endfunction

endpackage

// File: rtl/scfifo_ram.sv
// Simple dual-port storage for scfifo: one synchronous write port and one
// registered read port. The read samples the array before a same-edge write.
module scfifo_ram
  import bster_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_d;
  logic [DATA_WIDTH-1:0] data_out_q;

  // Combinational array lookup feeding the read register
  always_comb begin
    data_out_d = mem[addr_out];
  end

  // Write port and registered read port; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_in] <= data_in;
    end
    data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;

endmodule

// File: rtl/scfifo.sv
// Single-clock first-word-fall-through FIFO controller around scfifo_ram.
// The head entry is always pre-fetched into the RAM read register so that
// out_data is valid in the same cycle out_valid is high.
module scfifo
  import bster_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned         PTR_W     = ADDR_WIDTH + 1;
  localparam int unsigned         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [PTR_W-1:0]    PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]    DEPTH_CNT = PTR_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q,  count_d;
  logic             out_valid_q, out_valid_d;

  logic             push;
  logic             pop;
  qop_e             op;
  logic             full_w;

  // Handshake strobes and the queue operation for this cycle
  always_comb begin
    full_w = (count_q == DEPTH_CNT);
    push   = in_valid & ~full_w;
    pop    = out_valid_q & out_ready;
    op     = qop_encode(push, pop);
  end

  // Next pointer and occupancy values; the read pointer advances on pop so
  // that the RAM read address always targets the next head
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (op)
      QOP_PUSH: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        count_d  = count_q + PTR_ONE;
      end
      QOP_POP: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - PTR_ONE;
      end
      QOP_BOTH: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      default: ;
    endcase
  end

  // Head becomes visible only for entries committed before this cycle:
  // a same-cycle write is not yet in the RAM read register
  always_comb begin
    out_valid_d = ((count_q - PTR_W'(pop)) != '0);
  end

  // Pointer and occupancy registers
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Output-valid register
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
    end
  end

  scfifo_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk      (aclk),
    .wr_en    (push),
    .addr_in  (wr_ptr_q[ADDR_WIDTH-1:0]),
    .data_in  (in_data),
    .addr_out (rd_ptr_d[ADDR_WIDTH-1:0]),
    .data_out (out_data)
  );

  assign in_ready  = ~full_w;
  assign full      = full_w;
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign out_valid = out_valid_q;

  // Occupancy never exceeds the storage size
  a_count_bound: assert property (@(posedge aclk) disable iff (arst) count_q <= DEPTH_CNT);

  // Occupancy always equals the pointer distance
  a_ptr_count: assert property (@(posedge aclk) disable iff (arst) (wr_ptr_q - rd_ptr_q) == count_q);

  // A valid head implies at least one committed entry
  a_valid_nonempty: assert property (@(posedge aclk) disable iff (arst) out_valid_q |-> (count_q != '0));

endmodule

// File: tb/tb_scfifo.sv
module tb_scfifo;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          aclk = 1'b0;
  logic          arst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;

  scfifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk      (aclk),
    .arst      (arst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Reference model: ordered list of accepted entries with the cycle they were accepted in
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;
  ent_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard: mid-cycle, compare DUT against the model, then retire/accept per handshake
  int  m_n;
  bit  m_v;
  always @(negedge aclk) begin
    if (!arst) begin
      m_n = exp_q.size();
      // An accepted entry becomes the visible head two cycles after acceptance
      m_v = (m_n > 0) && (exp_q[0].t <= cyc - 2);
      chk("count", 32'(count), 32'(m_n));
      chk("full", 32'(full), 32'(m_n == DEPTH));
      chk("empty", 32'(empty), 32'(m_n == 0));
      chk("in_ready", 32'(in_ready), 32'(m_n < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(m_v));
      if (m_v) chk("out_data", 32'(out_data), 32'(exp_q[0].d));
      if (m_v && out_ready) void'(exp_q.pop_front());
      if (in_valid && (m_n < DEPTH)) exp_q.push_back('{d: in_data, t: cyc});
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge aclk);
    #1;
  endtask

  task automatic async_reset();
    #2 arst = 1'b1;
    exp_q.delete();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    @(posedge aclk);
    #1 arst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge aclk);
    #1 arst = 1'b0;
    step(1'b0, 8'h00, 1'b0);

    // Latency: single push into empty FIFO
    step(1'b1, 8'hA5, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0);

    // Fill to full, hold an extra word, then drain
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
    repeat (2) step(1'b1, 8'h05, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b1);

    // Streaming: 64 beats with continuous ready
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i + 8'h40), 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // Backpressure
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    repeat (5) step(1'b0, 8'h00, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Full with simultaneous pop attempt, then push the following cycle
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hD0, 1'b1);
    step(1'b1, 8'hD0, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    repeat (7) step(1'b0, 8'h00, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    repeat (8) step(1'b0, 8'h00, 1'b1);

    // Async reset mid-stream, then reuse
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'($urandom_range(0, 1)));
    in_valid = 1'b0;
    out_ready = 1'b0;
    async_reset();
    step(1'b1, 8'h7E, 1'b0);
    repeat (2) step(1'b0, 8'h00, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Random traffic across another reset
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    async_reset();
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    repeat (8) step(1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
